// File: rtl/data_compare_pkg.sv
// -----------------------------------------------------------------------------
// data_compare_pkg
// Shared definitions for the sequential magnitude comparator:
//   - one-hot result encodings {gt,lt,eq}
//   - controller state type
//   - cascade-input resolution (priority gt > lt > eq)
// -----------------------------------------------------------------------------
package data_compare_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_e;

    // An invalid or empty cascade word (e.g. 3'b000) degrades to "equal",
    // so a chain whose head leaves the cascade tied low still behaves sensibly.
    function automatic logic [2:0] resolve_cascade(input logic [2:0] casc);
        logic [2:0] res;
        if (casc[2]) begin
            res = CMP_GT;
        end else if (casc[1]) begin
            res = CMP_LT;
        end else begin
            res = CMP_EQ;
        end
        return res;
    endfunction

endpackage

// File: rtl/chunk_compare.sv
// -----------------------------------------------------------------------------
// chunk_compare
// Combinational magnitude compare of one CHUNK_W-bit slice.
// Ports:
//   a, b       slice operands
//   signed_en  treat the slice as two's complement (used for the MSB slice)
//   gt, lt     a > b, a < b (both low when equal)
// -----------------------------------------------------------------------------
module chunk_compare #(
    parameter int CHUNK_W = 4
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               signed_en,
    output logic               gt,
    output logic               lt
);

    logic [CHUNK_W-1:0] a_m;
    logic [CHUNK_W-1:0] b_m;

    // Flipping the sign bit maps two's-complement ordering onto unsigned
    // ordering, so one unsigned comparator serves both modes.
    always_comb begin
        a_m = a;
        b_m = b;
        if (signed_en) begin
            a_m[CHUNK_W-1] = ~a[CHUNK_W-1];
            b_m[CHUNK_W-1] = ~b[CHUNK_W-1];
        end
        gt = (a_m > b_m);
        lt = (a_m < b_m);
    end

endmodule

// File: rtl/seq_data_compare.sv
// -----------------------------------------------------------------------------
// seq_data_compare
// Multi-cycle cascadable magnitude comparator. Operands are examined one
// CHUNK_W slice per clock, MSB slice first, stopping at the first slice that
// differs. If every slice matches, the result comes from the cascade input.
// Ports:
//   iClk, iRst_n       clock (rising edge), asynchronous active-low reset
//   iStart / oReady    start request, accepted only while oReady=1
//   iData_a, iData_b   operands (W = CHUNK_W*NUM_CHUNKS), sampled on accept
//   iData              cascade-in one-hot {gt,lt,eq}, sampled on accept
//   iSigned            two's-complement compare, sampled on accept
//   oData              result one-hot {gt,lt,eq}, held until next result
//   oValid             one-cycle pulse when oData updates
//   oCycles            slices examined for the last result
// -----------------------------------------------------------------------------
module seq_data_compare #(
    parameter int CHUNK_W    = 4,
    parameter int NUM_CHUNKS = 4,
    parameter int CNT_W      = $clog2(NUM_CHUNKS + 1)
) (
    input  logic                          iClk,
    input  logic                          iRst_n,
    input  logic                          iStart,
    output logic                          oReady,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] iData_a,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] iData_b,
    input  logic [2:0]                    iData,
    input  logic                          iSigned,
    output logic [2:0]                    oData,
    output logic                          oValid,
    output logic [CNT_W-1:0]              oCycles
);

    import data_compare_pkg::*;

    localparam int W     = CHUNK_W * NUM_CHUNKS;
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CHUNKS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [2:0]         casc_q, casc_d;
    logic               signed_q, signed_d;
    logic [2:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;

    // Slice view of the captured operands, indexed by the down-counter.
    logic [CHUNK_W-1:0] a_slice [NUM_CHUNKS];
    logic [CHUNK_W-1:0] b_slice [NUM_CHUNKS];

    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_slice
        assign a_slice[gi] = a_q[gi*CHUNK_W +: CHUNK_W];
        assign b_slice[gi] = b_q[gi*CHUNK_W +: CHUNK_W];
    end

    logic slice_gt;
    logic slice_lt;
    logic slice_signed;

    // Only the top slice carries the sign; lower slices are plain magnitude.
    assign slice_signed = signed_q && (idx_q == IDX_MSB);

    chunk_compare #(
        .CHUNK_W (CHUNK_W)
    ) u_chunk_compare (
        .a         (a_slice[idx_q]),
        .b         (b_slice[idx_q]),
        .signed_en (slice_signed),
        .gt        (slice_gt),
        .lt        (slice_lt)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        casc_d   = casc_q;
        signed_d = signed_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        cycles_d = cycles_q;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    a_d      = iData_a;
                    b_d      = iData_b;
                    casc_d   = iData;
                    signed_d = iSigned;
                    idx_d    = IDX_MSB;
                    state_d  = CMP;
                end
            end
            CMP: begin
                if (slice_gt || slice_lt) begin
                    data_d   = slice_gt ? CMP_GT : CMP_LT;
                    valid_d  = 1'b1;
                    cycles_d = CNT_FULL - CNT_W'(idx_q);
                    state_d  = IDLE;
                end else if (idx_q == '0) begin
                    data_d   = resolve_cascade(casc_q);
                    valid_d  = 1'b1;
                    cycles_d = CNT_FULL;
                    state_d  = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered ready mirrors the next state so oReady rises together
        // with oValid on the deciding edge.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            casc_q   <= '0;
            signed_q <= 1'b0;
            data_q   <= CMP_EQ;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            casc_q   <= casc_d;
            signed_q <= signed_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            cycles_q <= cycles_d;
        end
    end

    assign oReady  = ready_q;
    assign oData   = data_q;
    assign oValid  = valid_q;
    assign oCycles = cycles_q;

endmodule

// File: tb/tb_seq_data_compare.sv
// -----------------------------------------------------------------------------
// tb_seq_data_compare
// Self-checking bench for seq_data_compare at default parameters (W=16).
// Expected results are pushed when a compare is launched and popped by a
// monitor whenever oValid is seen.
// -----------------------------------------------------------------------------
module tb_seq_data_compare;

    localparam int CHUNK_W    = 4;
    localparam int NUM_CHUNKS = 4;
    localparam int W          = CHUNK_W * NUM_CHUNKS;
    localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);

    logic             iClk;
    logic             iRst_n;
    logic             iStart;
    logic             oReady;
    logic [W-1:0]     iData_a;
    logic [W-1:0]     iData_b;
    logic [2:0]       iData;
    logic             iSigned;
    logic [2:0]       oData;
    logic             oValid;
    logic [CNT_W-1:0] oCycles;

    seq_data_compare #(
        .CHUNK_W    (CHUNK_W),
        .NUM_CHUNKS (NUM_CHUNKS),
        .CNT_W      (CNT_W)
    ) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iStart  (iStart),
        .oReady  (oReady),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .iData   (iData),
        .iSigned (iSigned),
        .oData   (oData),
        .oValid  (oValid),
        .oCycles (oCycles)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [2:0] data;
        int         cycles;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word compare decides direction; the deciding slice is
    // the one holding the highest differing bit.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] casc, input logic sgn,
                                  output logic [2:0] d, output int ncyc);
        logic [W-1:0] diff;
        int hi;
        diff = a ^ b;
        hi = -1;
        for (int i = 0; i < W; i++) if (diff[i]) hi = i;
        if (hi < 0) begin
            ncyc = NUM_CHUNKS;
            if (casc[2])      d = 3'b100;
            else if (casc[1]) d = 3'b010;
            else              d = 3'b001;
        end else begin
            ncyc = NUM_CHUNKS - hi / CHUNK_W;
            if (sgn) d = ($signed(a) > $signed(b)) ? 3'b100 : 3'b010;
            else     d = (a > b) ? 3'b100 : 3'b010;
        end
    endfunction

    // Monitor: counts edges and scores every oValid pulse.
    always @(posedge iClk) begin
        cyc++;
        #1;
        if (oValid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(oValid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result: oData=%b oCycles=%0d latency=%0d (exp %b/%0d/%0d)",
                         oData, oCycles, cyc - e.acc, e.data, e.cycles, e.cycles);
                check("odata", 32'(oData), 32'(e.data));
                check("ocycles", 32'(oCycles), 32'(e.cycles));
                check("latency", 32'(cyc - e.acc), 32'(e.cycles));
                check("ready_with_valid", 32'(oReady), 32'd1);
            end
        end
    end

    // Waits for oReady, drives a request and leaves iStart high.
    task automatic drive_push(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2:0] casc, input logic sgn,
                              output int ncyc, output int acc);
        exp_t e;
        int   n;
        n = 0;
        @(negedge iClk);
        while (oReady !== 1'b1 && n < 50) begin
            @(negedge iClk);
            n++;
        end
        if (oReady !== 1'b1) check("ready_timeout", 32'(oReady), 32'd1);
        iData_a = a;
        iData_b = b;
        iData   = casc;
        iSigned = sgn;
        iStart  = 1'b1;
        model(a, b, casc, sgn, e.data, e.cycles);
        e.acc = cyc + 1;
        sb.push_back(e);
        ncyc = e.cycles;
        acc  = e.acc;
    endtask

    task automatic start_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] casc, input logic sgn);
        int ncyc, acc;
        drive_push(a, b, casc, sgn, ncyc, acc);
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge iClk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge iClk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc, acc, ncyc2;
        exp_t e2;
        logic [W-1:0] ra, rb;

        iRst_n  = 1'b0;
        iStart  = 1'b0;
        iData_a = '0;
        iData_b = '0;
        iData   = 3'b000;
        iSigned = 1'b0;
        repeat (3) @(negedge iClk);
        check("rst_ready", 32'(oReady), 32'd1);
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_odata", 32'(oData), 32'b001);
        check("rst_ocycles", 32'(oCycles), 32'd0);
        iRst_n = 1'b1;
        @(negedge iClk);

        // Early decision and cascade pass-through
        start_cmp(16'h0600, 16'h0F00, 3'b000, 1'b0); drain();
        start_cmp(16'h1234, 16'h1234, 3'b100, 1'b0); drain();
        start_cmp(16'h1234, 16'h1234, 3'b010, 1'b0); drain();
        start_cmp(16'h1234, 16'h1234, 3'b001, 1'b0); drain();
        // Signed vs unsigned on the top bit
        start_cmp(16'h8000, 16'h0001, 3'b001, 1'b1); drain();
        start_cmp(16'h8000, 16'h0001, 3'b001, 1'b0); drain();
        // Cascade priority
        start_cmp(16'hABCD, 16'hABCD, 3'b011, 1'b0); drain();
        start_cmp(16'hABCD, 16'hABCD, 3'b000, 1'b0); drain();
        start_cmp(16'hABCD, 16'hABCD, 3'b111, 1'b1); drain();

        // Random operands, often differing only in a low slice
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? 16'($urandom) : (ra ^ (16'd1 << $urandom_range(0, 15)));
            start_cmp(ra, rb, 3'($urandom), 1'($urandom));
            drain();
        end

        // iStart pulsed while busy must be ignored
        drive_push(16'h1234, 16'h1234, 3'b100, 1'b0, ncyc, acc);
        @(negedge iClk);
        iStart = 1'b0;
        @(negedge iClk);
        iStart  = 1'b1;
        iData_a = 16'h0000;
        iData_b = 16'hFFFF;
        iData   = 3'b010;
        check("busy_ready", 32'(oReady), 32'd0);
        @(negedge iClk);
        iStart = 1'b0;
        drain();

        // Back-to-back: iStart held high through the oValid cycle
        drive_push(16'h00F0, 16'h0030, 3'b001, 1'b0, ncyc, acc);
        @(negedge iClk);
        iData_a = 16'h5555;
        iData_b = 16'h5556;
        iData   = 3'b001;
        iSigned = 1'b0;
        model(16'h5555, 16'h5556, 3'b001, 1'b0, e2.data, ncyc2);
        e2.cycles = ncyc2;
        e2.acc    = acc + ncyc + 1;
        sb.push_back(e2);
        repeat (ncyc + 1) @(negedge iClk);
        iStart = 1'b0;
        drain();

        // Leave a non-reset result on the outputs, then reset mid-compare
        start_cmp(16'h0600, 16'h0F00, 3'b000, 1'b0); drain();
        iData_a = 16'h4242;
        iData_b = 16'h4242;
        iData   = 3'b100;
        iStart  = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        @(negedge iClk);
        iRst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(oReady), 32'd1);
        check("midrst_valid", 32'(oValid), 32'd0);
        check("midrst_odata", 32'(oData), 32'b001);
        check("midrst_ocycles", 32'(oCycles), 32'd0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        repeat (8) @(negedge iClk);
        check("post_rst_ready", 32'(oReady), 32'd1);
        check("post_rst_odata", 32'(oData), 32'b001);

        // Still functional after reset
        start_cmp(16'hF000, 16'h7000, 3'b000, 1'b1); drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
